// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: control-transfer
// kind encoding, counter initial value and derived-width helpers.
package bp_pkg;

  // Resolved control-transfer kinds reported by execute.
  localparam logic [2:0] KIND_BR   = 3'd0;
  localparam logic [2:0] KIND_JAL  = 3'd1;
  localparam logic [2:0] KIND_JALR = 3'd2;
  localparam logic [2:0] KIND_CALL = 3'd3;
  localparam logic [2:0] KIND_RET  = 3'd4;

  // Smallest r >= 1 such that 2**r >= n; keeps pointer widths non-zero.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int b = 1; b < 31; b++) begin
      if ((32'sd1 << b) < n) begin
        r = b + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Weakly-taken counter value: MSB set, remaining bits clear.
  function automatic logic [31:0] ctr_init(input int w);
    return 32'd1 << (w - 1);
  endfunction

  // Kinds 5..7 are not real control transfers and are ignored.
  function automatic logic kind_legal(input logic [2:0] k);
    return (k <= KIND_RET);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty does nothing. Push and pop never coincide.
module ras_stack
  import bp_pkg::*;
#(
  parameter int PC_W      = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty
);

  localparam int PTR_W = clog2_min1(RAS_DEPTH);
  localparam int CNT_W = clog2_min1(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_r;       // next slot to write
  logic [CNT_W-1:0] cnt_r;       // valid entries, saturates at RAS_DEPTH
  logic [PTR_W-1:0] top_ptr_s;
  logic [PTR_W-1:0] ptr_inc_s;

  // Wrap-around pointer arithmetic for arbitrary depths.
  always_comb begin
    top_ptr_s = LAST_PTR;
    ptr_inc_s = {PTR_W{1'b0}};
    if (ptr_r == {PTR_W{1'b0}}) begin
      top_ptr_s = LAST_PTR;
    end else begin
      top_ptr_s = ptr_r - PTR_W'(1);
    end
    if (ptr_r == LAST_PTR) begin
      ptr_inc_s = {PTR_W{1'b0}};
    end else begin
      ptr_inc_s = ptr_r + PTR_W'(1);
    end
  end

  // Return-address storage; contents are meaningless while count is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_r[ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (push) begin
      ptr_r <= ptr_inc_s;
      if (cnt_r != FULL_CNT) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else if (pop && (cnt_r != {CNT_W{1'b0}})) begin
      ptr_r <= top_ptr_s;
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  assign top   = mem_r[top_ptr_s];
  assign empty = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with per-entry saturating
// direction counters plus a return-address stack. Lookups are combinational
// from registered state; training from execute lands at the next clock edge.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W      = 12,
  parameter int ENTRIES   = 16,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4,
  parameter int PERF_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   f_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              u_valid,
  input  logic [PC_W-1:0]   u_pc,
  input  logic [2:0]        u_kind,
  input  logic              u_taken,
  input  logic [PC_W-1:0]   u_target,
  input  logic              u_mispredict,
  input  logic              flush,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = clog2_min1(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  // BTB storage, flop-based for asynchronous reads.
  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r  [ENTRIES];
  logic [PC_W-1:0]    tgt_r  [ENTRIES];
  logic [2:0]         kind_r [ENTRIES];
  logic [CTR_W-1:0]   ctr_r  [ENTRIES];
  logic [PERF_W-1:0]  perf_r;

  logic [IDX_W-1:0] f_idx_s;
  logic [TAG_W-1:0] f_tag_s;
  logic             f_hit_s;
  logic [IDX_W-1:0] u_idx_s;
  logic [TAG_W-1:0] u_tag_s;
  logic             u_hit_s;
  logic             upd_s;
  logic             u_is_br_s;
  logic             u_tk_s;
  logic             alloc_s;
  logic             wr_entry_s;
  logic             ctr_upd_s;
  logic [CTR_W-1:0] ctr_next_s;
  logic             ras_push_s;
  logic             ras_pop_s;
  logic [PC_W-1:0]  ras_top_s;
  logic             ras_empty_s;
  logic             unused_s;

  // Byte-offset bits of the PCs carry no information for an RV32 predictor.
  assign unused_s = ^{f_pc[1:0], u_pc[1:0]};

  assign f_idx_s = f_pc[IDX_W+1:2];
  assign f_tag_s = f_pc[PC_W-1:IDX_W+2];
  assign f_hit_s = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);

  assign u_idx_s = u_pc[IDX_W+1:2];
  assign u_tag_s = u_pc[PC_W-1:IDX_W+2];
  assign u_hit_s = valid_r[u_idx_s] && (tag_r[u_idx_s] == u_tag_s);

  // Classify the resolved instruction and decide what the BTB does with it.
  always_comb begin
    upd_s      = u_valid && kind_legal(u_kind);
    u_is_br_s  = (u_kind == KIND_BR);
    u_tk_s     = !u_is_br_s || u_taken;
    // Flush wins over allocation; hit-side training still happens.
    alloc_s    = upd_s && !u_hit_s && u_tk_s && !flush;
    wr_entry_s = alloc_s || (upd_s && u_hit_s && u_tk_s);
    ctr_upd_s  = upd_s && u_hit_s && u_is_br_s;
    ras_push_s = upd_s && (u_kind == KIND_CALL);
    ras_pop_s  = upd_s && (u_kind == KIND_RET);
  end

  // Saturating next value for the direction counter being trained.
  always_comb begin
    ctr_next_s = ctr_r[u_idx_s];
    if (u_taken) begin
      if (ctr_r[u_idx_s] != CTR_MAX) begin
        ctr_next_s = ctr_r[u_idx_s] + CTR_W'(1);
      end else begin
        ctr_next_s = ctr_r[u_idx_s];
      end
    end else begin
      if (ctr_r[u_idx_s] != {CTR_W{1'b0}}) begin
        ctr_next_s = ctr_r[u_idx_s] - CTR_W'(1);
      end else begin
        ctr_next_s = ctr_r[u_idx_s];
      end
    end
  end

  // Valid bits: cleared by reset or flush, set on allocation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (flush) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (alloc_s) begin
      valid_r[u_idx_s] <= 1'b1;
    end
  end

  // Direction counters: weakly taken on allocation, trained on BR hits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= {CTR_W{1'b0}};
      end
    end else if (alloc_s) begin
      ctr_r[u_idx_s] <= CTR_INIT;
    end else if (ctr_upd_s) begin
      ctr_r[u_idx_s] <= ctr_next_s;
    end
  end

  // Tag, target and kind storage; only meaningful while the valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_entry_s) begin
      tag_r[u_idx_s]  <= u_tag_s;
      tgt_r[u_idx_s]  <= u_target;
      kind_r[u_idx_s] <= u_kind;
    end
  end

  // Saturating count of mispredictions reported by execute.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_r <= {PERF_W{1'b0}};
    end else if (u_mispredict && (perf_r != PERF_MAX)) begin
      perf_r <= perf_r + PERF_W'(1);
    end
  end

  assign perf_mispredicts = perf_r;

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (u_pc + PC_W'(4)),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );

  // Fetch-side prediction; returns prefer the RAS when it holds an address.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = f_pc + PC_W'(4);
    if (f_hit_s && ((kind_r[f_idx_s] != KIND_BR) || ctr_r[f_idx_s][CTR_W-1])) begin
      pred_taken = 1'b1;
      if ((kind_r[f_idx_s] == KIND_RET) && !ras_empty_s) begin
        pred_target = ras_top_s;
      end else begin
        pred_target = tgt_r[f_idx_s];
      end
    end else begin
      pred_taken  = 1'b0;
      pred_target = f_pc + PC_W'(4);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// training/lookup traffic checked against a behavioural predictor model.
module tb_branch_predictor;

  localparam int PC_W      = 12;
  localparam int ENTRIES   = 16;
  localparam int CTR_W     = 2;
  localparam int RAS_DEPTH = 4;
  localparam int PERF_W    = 4;
  localparam int PC_MOD    = 1 << PC_W;
  localparam int CTR_TOP   = (1 << CTR_W) - 1;
  localparam int CTR_HALF  = 1 << (CTR_W - 1);
  localparam int PERF_TOP  = (1 << PERF_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   f_pc;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              u_valid;
  logic [PC_W-1:0]   u_pc;
  logic [2:0]        u_kind;
  logic              u_taken;
  logic [PC_W-1:0]   u_target;
  logic              u_mispredict;
  logic              flush;
  logic [PERF_W-1:0] perf_mispredicts;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  branch_predictor #(
    .PC_W(PC_W), .ENTRIES(ENTRIES), .CTR_W(CTR_W),
    .RAS_DEPTH(RAS_DEPTH), .PERF_W(PERF_W)
  ) dut (
    .clock(clock), .reset(reset), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .u_valid(u_valid), .u_pc(u_pc), .u_kind(u_kind), .u_taken(u_taken),
    .u_target(u_target), .u_mispredict(u_mispredict), .flush(flush),
    .perf_mispredicts(perf_mispredicts)
  );

  // Behavioural model: BTB as plain arrays indexed by arithmetic on the PC.
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_kind  [ENTRIES];
  int m_ctr   [ENTRIES];
  int m_ras   [$];
  int m_perf;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_ctr[i] = 0;
    end
    m_ras.delete();
    m_perf = 0;
  endfunction

  function automatic void model_predict(input int pc, output bit tk, output int tgt);
    int i, t;
    bit hit;
    i   = (pc / 4) % ENTRIES;
    t   = pc / (4 * ENTRIES);
    hit = m_valid[i] && (m_tag[i] == t);
    tk  = hit && (m_kind[i] != 0 || m_ctr[i] >= CTR_HALF);
    if (tk && m_kind[i] == 4 && m_ras.size() > 0) tgt = m_ras[$];
    else if (tk) tgt = m_tgt[i];
    else tgt = (pc + 4) % PC_MOD;
  endfunction

  function automatic void model_update(input bit v, input int pc, input int kind,
                                       input bit tk_in, input int tgt, input bit mis,
                                       input bit fl);
    int i, t;
    bit hit, tk;
    if (mis && m_perf < PERF_TOP) m_perf++;
    if (v && kind <= 4) begin
      i   = (pc / 4) % ENTRIES;
      t   = pc / (4 * ENTRIES);
      hit = m_valid[i] && (m_tag[i] == t);
      tk  = (kind != 0) || tk_in;
      if (hit) begin
        if (kind == 0) m_ctr[i] = tk ? ((m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP)
                                     : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (tk) begin m_tgt[i] = tgt; m_kind[i] = kind; end
      end else if (tk && !fl) begin
        m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = tgt; m_kind[i] = kind; m_ctr[i] = CTR_HALF;
      end
      if (kind == 3) begin
        if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
        m_ras.push_back((pc + 4) % PC_MOD);
      end else if (kind == 4 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    if (fl) for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
  endfunction

  // Drive one training cycle, advance the model at the same edge.
  task automatic do_update(input bit v, input int pc, input int kind, input bit tk,
                           input int tgt, input bit mis, input bit fl);
    u_valid = v; u_pc = PC_W'(pc); u_kind = 3'(kind); u_taken = tk;
    u_target = PC_W'(tgt); u_mispredict = mis; flush = fl;
    @(posedge clock);
    model_update(v, pc, kind, tk, tgt, mis, fl);
    #1;
    u_valid = 1'b0; u_mispredict = 1'b0; flush = 1'b0;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    bit et; int eg;
    reset = 1'b0; f_pc = 12'h040; u_valid = 1'b0; u_pc = '0; u_kind = 3'd0;
    u_taken = 1'b0; u_target = '0; u_mispredict = 1'b0; flush = 1'b0;
    model_reset();
    #3;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 12'h044 || perf_mispredicts !== 4'd0) begin
      miscompares++;
      $display("FAIL reset: taken=%0b target=%h perf=%0d, want 0 044 0", pred_taken, pred_target, perf_mispredicts);
    end
    model_predict(32'h040, et, eg);
    vectors++;
    if (pred_taken !== et || pred_target !== PC_W'(eg)) begin
      miscompares++;
      $display("FAIL reset_model: got %0b/%h want %0b/%h", pred_taken, pred_target, et, eg);
    end
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_branch_counter();
    do_update(1, 32'h100, 0, 1, 32'h080, 0, 0);
    f_pc = 12'h100; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 12'h080) begin
      miscompares++;
      $display("FAIL br_alloc: got %0b/%h want 1/080", pred_taken, pred_target);
    end
    do_update(1, 32'h100, 0, 0, 32'h000, 0, 0);
    do_update(1, 32'h100, 0, 0, 32'h000, 0, 0);
    #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 12'h104) begin
      miscompares++;
      $display("FAIL br_not_taken: got %0b/%h want 0/104", pred_taken, pred_target);
    end
    for (int k = 0; k < 3; k++) do_update(1, 32'h100, 0, 1, 32'h080, 0, 0);
    do_update(1, 32'h100, 0, 0, 32'h000, 0, 0);
    #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 12'h080) begin
      miscompares++;
      $display("FAIL br_saturate: got %0b/%h want 1/080", pred_taken, pred_target);
    end
  endtask

  task automatic test_ras();
    bit et; int eg;
    do_update(1, 32'h200, 3, 1, 32'h500, 0, 0);
    do_update(1, 32'h300, 4, 1, 32'h204, 0, 0);
    do_update(1, 32'h210, 3, 1, 32'h600, 0, 0);
    f_pc = 12'h300; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 12'h214) begin
      miscompares++;
      $display("FAIL ras_top: got %0b/%h want 1/214", pred_taken, pred_target);
    end
    for (int k = 0; k <= RAS_DEPTH; k++) do_update(1, 32'h404 + 8 * k, 3, 1, 32'h700, 0, 0);
    for (int k = 0; k <= RAS_DEPTH; k++) begin
      f_pc = 12'h300; #1;
      model_predict(32'h300, et, eg);
      vectors++;
      if (pred_taken !== et || pred_target !== PC_W'(eg)) begin
        miscompares++;
        $display("FAIL ras_ret%0d: got %0b/%h want %0b/%h", k, pred_taken, pred_target, et, eg);
      end
      if (k == RAS_DEPTH) begin
        vectors++;
        if (pred_target !== 12'h204) begin
          miscompares++;
          $display("FAIL ras_empty_fallback: got %h want 204", pred_target);
        end
      end
      do_update(1, 32'h300, 4, 1, 32'h204, 0, 0);
    end
  endtask

  task automatic test_alias();
    do_update(1, 32'h100, 0, 1, 32'h0C0, 0, 0);
    do_update(1, 32'h140, 0, 1, 32'h0E0, 0, 0);
    f_pc = 12'h100; #1;
    vectors++;
    if (pred_taken !== 1'b0 || pred_target !== 12'h104) begin
      miscompares++;
      $display("FAIL alias_evicted: got %0b/%h want 0/104", pred_taken, pred_target);
    end
    f_pc = 12'h140; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 12'h0E0) begin
      miscompares++;
      $display("FAIL alias_new: got %0b/%h want 1/0E0", pred_taken, pred_target);
    end
  endtask

  task automatic test_flush();
    int pcs [5] = '{32'h500, 32'h140, 32'h300, 32'h210, 32'h404};
    int p0;
    p0 = m_perf;
    do_update(1, 32'h500, 1, 1, 32'h600, 1, 1);
    foreach (pcs[k]) begin
      f_pc = PC_W'(pcs[k]); #1;
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== PC_W'(pcs[k] + 4)) begin
        miscompares++;
        $display("FAIL flush_pc%h: got %0b/%h want 0/%h", pcs[k], pred_taken, pred_target, pcs[k] + 4);
      end
    end
    vectors++;
    if (perf_mispredicts !== PERF_W'(p0 + 1)) begin
      miscompares++;
      $display("FAIL flush_perf: got %0d want %0d", perf_mispredicts, p0 + 1);
    end
  endtask

  task automatic test_random();
    int pcs [8] = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h300, 32'hFFC, 32'h3FC, 32'h0C4};
    bit et; int eg, pc, kind, tgt;
    bit v, tk, mis, fl;
    for (int n = 0; n < 400; n++) begin
      pc   = pcs[$urandom_range(0, 7)];
      kind = $urandom_range(0, 7);
      kind = (kind > 5) ? $urandom_range(0, 4) : kind;
      v    = ($urandom_range(0, 3) != 0);
      tk   = $urandom_range(0, 1);
      tgt  = $urandom_range(0, PC_MOD / 4 - 1) * 4;
      mis  = ($urandom_range(0, 7) == 0);
      fl   = ($urandom_range(0, 39) == 0);
      f_pc = PC_W'(pcs[$urandom_range(0, 7)]);
      u_valid = v; u_pc = PC_W'(pc); u_kind = 3'(kind); u_taken = tk;
      u_target = PC_W'(tgt); u_mispredict = mis; flush = fl;
      #1;
      model_predict(int'(f_pc), et, eg);
      vectors++;
      if (pred_taken !== et || pred_target !== PC_W'(eg) || perf_mispredicts !== PERF_W'(m_perf)) begin
        miscompares++;
        $display("FAIL random%0d pc=%h: got %0b/%h/%0d want %0b/%h/%0d", n, f_pc,
                 pred_taken, pred_target, perf_mispredicts, et, eg, m_perf);
      end
      @(posedge clock);
      model_update(v, pc, kind, tk, tgt, mis, fl);
      #1;
    end
    u_valid = 1'b0; u_mispredict = 1'b0; flush = 1'b0;
  endtask

  task automatic test_perf_and_async_reset();
    apply_reset();
    do_update(1, 32'h180, 1, 1, 32'h2A0, 0, 0);
    for (int k = 0; k < 20; k++) do_update(0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (perf_mispredicts !== 4'd15 || m_perf != 15) begin
      miscompares++;
      $display("FAIL perf_saturate: got %0d want 15", perf_mispredicts);
    end
    f_pc = 12'h180; #1;
    vectors++;
    if (pred_taken !== 1'b1 || pred_target !== 12'h2A0) begin
      miscompares++;
      $display("FAIL pre_reset_hit: got %0b/%h want 1/2A0", pred_taken, pred_target);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (perf_mispredicts !== 4'd0 || pred_taken !== 1'b0 || pred_target !== 12'h184) begin
      miscompares++;
      $display("FAIL async_reset: got %0d %0b/%h want 0 0/184", perf_mispredicts, pred_taken, pred_target);
    end
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (pred_taken !== 1'b0 || perf_mispredicts !== 4'd0) begin
      miscompares++;
      $display("FAIL post_reset: got %0b %0d want 0 0", pred_taken, perf_mispredicts);
    end
  endtask

  initial begin
    test_reset();
    test_branch_counter();
    test_ras();
    test_alias();
    test_flush();
    test_random();
    test_perf_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
